// File: rtl/lua_pkg.sv
// rtl/lua_pkg.sv - Sequencer state type and Lua instruction-word layout constants
package lua_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT,
    ST_FAULT
  } seq_state_t;

  localparam int OP_W  = 6;
  localparam int A_W   = 8;
  localparam int B_W   = 9;
  localparam int C_W   = 9;

  localparam int OP_LSB = 0;
  localparam int A_LSB  = 6;
  localparam int C_LSB  = 14;
  localparam int B_LSB  = 23;

  localparam logic [OP_W-1:0] OP_RETURN = 6'd30;
  localparam logic [OP_W-1:0] OP_MAX    = 6'd37;

endpackage

// File: rtl/lua_insn_decode.sv
// rtl/lua_insn_decode.sv - Splits a Lua instruction word into fields and classifies the opcode
module lua_insn_decode
  import lua_pkg::*;
(
  input  logic [31:0]     i_insn,
  output logic [OP_W-1:0] o_op,
  output logic [A_W-1:0]  o_a,
  output logic [B_W-1:0]  o_b,
  output logic [C_W-1:0]  o_c,
  output logic            o_illegal,
  output logic            o_return
);

  // Field extraction; B sits above C in the word, so the offsets are not in port order
  always_comb begin
    o_op      = i_insn[OP_LSB +: OP_W];
    o_a       = i_insn[A_LSB  +: A_W];
    o_b       = i_insn[B_LSB  +: B_W];
    o_c       = i_insn[C_LSB  +: C_W];
    o_illegal = (o_op > OP_MAX);
    o_return  = (o_op == OP_RETURN);
  end

endmodule

// File: rtl/lua_stage_sequencer.sv
// rtl/lua_stage_sequencer.sv - Lua VM multi-cycle sequencer (optional EXEC watchdog: LUA_SEQ_TIMEOUT_EN)
module lua_stage_sequencer
  import lua_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_ex,
  input  logic             n_reset,
  input  logic             run,
  output logic             if_req,
  output logic [PC_W-1:0]  if_addr,
  input  logic             if_ack,
  input  logic [31:0]      if_data,
  output logic [5:0]       opecode,
  output logic [7:0]       operandA,
  output logic [8:0]       operandB,
  output logic [8:0]       operandC,
  output logic             ex_start,
  input  logic             ex_done,
  input  logic             ex_mem_req,
  input  logic             ex_jump,
  input  logic [PC_W-1:0]  ex_target,
  output logic             dm_req,
  input  logic             dm_ack,
  output logic             reg_we,
  output logic [CNT_W-1:0] retired,
  output logic             halted,
  output logic             fault
);

  seq_state_t       r_state;
  logic [PC_W-1:0]  r_pc;
  logic [31:0]      r_ir;
  logic [OP_W-1:0]  r_op;
  logic [A_W-1:0]   r_a;
  logic [B_W-1:0]   r_b;
  logic [C_W-1:0]   r_c;
  logic             r_if_req;
  logic             r_ex_start;
  logic             r_dm_req;
  logic             r_reg_we;
  logic             r_halted;
  logic             r_fault;
  logic             r_jump;
  logic [PC_W-1:0]  r_target;
  logic [CNT_W-1:0] r_retired;

  logic [OP_W-1:0]  w_op;
  logic [A_W-1:0]   w_a;
  logic [B_W-1:0]   w_b;
  logic [C_W-1:0]   w_c;
  logic             w_illegal;
  logic             w_return;

`ifdef LUA_SEQ_TIMEOUT_EN
  logic [7:0]       r_wdog;
`else
  // Watchdog compiled out; TIMEOUT is kept so both builds share one parameter list
  if (TIMEOUT > 0) begin : g_no_wdog
  end
`endif

  lua_insn_decode u_decode (
    .i_insn    (r_ir),
    .o_op      (w_op),
    .o_a       (w_a),
    .o_b       (w_b),
    .o_c       (w_c),
    .o_illegal (w_illegal),
    .o_return  (w_return)
  );

  // Sequencer FSM: owns PC, IR, operand ports, handshake strobes and the retire counter
  always_ff @(posedge clk_ex) begin
    if (!n_reset) begin
      r_state    <= ST_IDLE;
      r_pc       <= '0;
      r_ir       <= '0;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_c        <= '0;
      r_if_req   <= 1'b0;
      r_ex_start <= 1'b0;
      r_dm_req   <= 1'b0;
      r_reg_we   <= 1'b0;
      r_halted   <= 1'b0;
      r_fault    <= 1'b0;
      r_jump     <= 1'b0;
      r_target   <= '0;
      r_retired  <= '0;
`ifdef LUA_SEQ_TIMEOUT_EN
      r_wdog     <= '0;
`endif
    end else begin
      r_ex_start <= 1'b0;
      r_reg_we   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (run) begin
            r_state  <= ST_FETCH;
            r_if_req <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (if_ack) begin
            r_ir     <= if_data;
            r_if_req <= 1'b0;
            r_state  <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          r_op <= w_op;
          r_a  <= w_a;
          r_b  <= w_b;
          r_c  <= w_c;
          if (w_illegal) begin
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
          end else if (w_return) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else begin
            r_state    <= ST_EXEC;
            r_ex_start <= 1'b1;
`ifdef LUA_SEQ_TIMEOUT_EN
            r_wdog     <= '0;
`endif
          end
        end
        ST_EXEC: begin
          // r_ex_start marks the first EXEC cycle, where ex_done is stale and ignored
          if (!r_ex_start) begin
            if (ex_done) begin
              r_jump   <= ex_jump;
              r_target <= ex_target;
              if (ex_mem_req) begin
                r_state  <= ST_MEM;
                r_dm_req <= 1'b1;
              end else begin
                r_state  <= ST_WB;
                r_reg_we <= 1'b1;
              end
            end
`ifdef LUA_SEQ_TIMEOUT_EN
            else if (r_wdog == 8'(TIMEOUT - 1)) begin
              r_state <= ST_FAULT;
              r_fault <= 1'b1;
            end else begin
              r_wdog <= r_wdog + 8'd1;
            end
`endif
          end
        end
        ST_MEM: begin
          if (dm_ack) begin
            r_dm_req <= 1'b0;
            r_state  <= ST_WB;
            r_reg_we <= 1'b1;
          end
        end
        ST_WB: begin
          r_pc      <= r_jump ? r_target : r_pc + PC_W'(1);
          r_retired <= r_retired + CNT_W'(1);
          if (run) begin
            r_state  <= ST_FETCH;
            r_if_req <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_HALT, ST_FAULT: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign if_req   = r_if_req;
  assign if_addr  = r_pc;
  assign opecode  = r_op;
  assign operandA = r_a;
  assign operandB = r_b;
  assign operandC = r_c;
  assign ex_start = r_ex_start;
  assign dm_req   = r_dm_req;
  assign reg_we   = r_reg_we;
  assign retired  = r_retired;
  assign halted   = r_halted;
  assign fault    = r_fault;

endmodule
